lbr_controller: RTL and testbench
=================================

// Module: lbr_controller
// PURPOSE
//  Sequences the 3-write/1-read LBR register file as a circular last-branch-record buffer.
//  Each retired branch is one record of three words (from, to, info), written in one cycle via write ports 0/1/2.
//  On request, replays stored records oldest->newest over a valid/ready stream for the ROP checker.
//  Sits between core retire stage, lbrRegFile and checker; sole owner of all regfile ports.
// PARAMETERS
//  DATA_WIDTH   16  width of branch addresses/info and regfile words
//  ADDR_BITS     5  regfile select width
//  NUM_RECORDS   8  record slots; 3*NUM_RECORDS <= 2**ADDR_BITS
//  DROP_W        8  width of dropped-branch counter
// PORTS
//  clock        in   1           rising-edge clock
//  reset        in   1           asynchronous, active-low reset
//  br_valid     in   1           retired-branch strobe, one record per cycle
//  br_from      in   DATA_WIDTH  branch source address
//  br_to        in   DATA_WIDTH  branch target address
//  br_info      in   DATA_WIDTH  [3:0] one-hot type: 0 call, 1 ret, 2 jalr, 3 cond; rest opaque
//  filter_mask  in   4           type enables (used only with LBR_FILTER_EN)
//  clear        in   1           empty the buffer (pointer reset; contents untouched)
//  dump_req     in   1           start replay
//  dump_valid   out  1           replay word valid
//  dump_data    out  DATA_WIDTH  replay word
//  dump_last    out  1           final word of replay
//  dump_ready   in   1           checker accepts word
//  busy         out  1           replay in progress
//  rec_count    out  clog2(NUM_RECORDS+1)  valid records held
//  drop_count   out  DROP_W      branches dropped during replay, saturating
//  wEn0/1/2     out  1           regfile write enables
//  write_sel0/1/2 out ADDR_BITS  regfile write selects
//  write_data0/1/2 out DATA_WIDTH regfile write data
//  read_sel     out  ADDR_BITS   regfile read select
//  read_data    in   DATA_WIDTH  regfile read data, combinational on read_sel
// BEHAVIOUR
//  Reset (reset==0): state RECORD; head=0, rec_count=0, drop_count=0; all outputs 0.
//  States: RECORD, DUMP. Record slot s occupies entries 3s (from), 3s+1 (to), 3s+2 (info).
//  RECORD: accept = br_valid & type-pass -> wEn0..2=1 combinationally, sel=3*head+{0,1,2}, data=from/to/info;
//   regfile captures on the same edge; head wraps NUM_RECORDS-1 -> 0; rec_count saturates at NUM_RECORDS (oldest overwritten).
//  clear in RECORD: head=0, rec_count=0; with simultaneous accept, the branch goes to slot 0 -> head=1, rec_count=1.
//  dump_req in RECORD with rec_count>0 -> DUMP next cycle; a branch accepted in that same cycle is included.
//   dump_req with rec_count==0 ignored (no dump_valid, busy stays 0).
//  DUMP: busy=1, dump_valid=1, oldest slot=(head-rec_count) mod NUM_RECORDS; word w -> read_sel=3*slot+(w%3);
//   dump_data=read_data; advance only on dump_valid&dump_ready; dump_data stable while stalled.
//   dump_last on word 3*rec_count-1; its handshake -> RECORD; replay non-destructive (head/rec_count unchanged).
//  During DUMP: wEn0..2=0; br_valid dropped, drop_count++ (saturate at all-ones); clear and dump_req ignored.
//  Reset asserted mid-replay: immediate return to reset state; partial stream abandoned.
//  read_sel=0 in RECORD. drop_count cleared only by reset.
// CONFIGURATION
//  LBR_FILTER_EN defined: type-pass = |(br_info[3:0] & filter_mask); filtered branches not recorded, not counted as drops.
//  Undefined: type-pass=1; filter_mask ignored.
// STRUCTURE
//  Package lbr_pkg: state enum (RECORD, DUMP), word offsets FROM=0/TO=1/INFO=2, type bit indices, record-to-entry function.
//  One sub-module: lbr_dump_seq (slot/word counters, read_sel generation, valid/ready/last).
//  Regfile itself is instantiated by the parent, not here.
// TESTING (NUM_RECORDS=8, DATA_WIDTH=16)
//  Reset, 3 branches from=10/20/30 -> rec_count=3, regfile entries 0..8 = 10,11,12,20,21,22,30,31,32 (to=from+1, info=from+2).
//  10 branches i=1..10 then dump, ready=1 -> rec_count=8; 24 words starting from=3, ending info of 10; dump_last on word 24.
//  Dump with ready toggling every other cycle -> each word held stable until accepted; same 24-word sequence.
//  5 br_valid during dump -> wEn never asserted, drop_count=5, rec_count unchanged; 300 drops -> drop_count=255.
//  clear with br_valid (from=0x55) -> rec_count=1, entries 0..2 = 0x55,0x56,0x57; dump_req at rec_count=0 -> no dump_valid.
//  LBR_FILTER_EN, mask=4'b0010, call then ret -> only ret recorded; reset low mid-dump -> dump_valid=0 immediately, rec_count=0.

Source files
------------

// File: rtl/lbr_pkg.sv
// Shared types and helpers for the last-branch-record controller.
package lbr_pkg;

  typedef enum logic {RECORD = 1'b0, DUMP = 1'b1} lbr_state_e;

  // Word offsets of a record inside its three-entry slot
  localparam logic [1:0] FROM = 2'd0;
  localparam logic [1:0] TO   = 2'd1;
  localparam logic [1:0] INFO = 2'd2;

  // One-hot branch type bit positions in br_info[3:0]
  localparam int T_CALL = 0;
  localparam int T_RET  = 1;
  localparam int T_JALR = 2;
  localparam int T_COND = 3;

  // Regfile entry holding word 'word' of record slot 'slot'
  function automatic int unsigned rec_entry(input int unsigned slot, input logic [1:0] word);
    return 3 * slot + 32'(word);
  endfunction

endpackage

// File: rtl/lbr_controller_if.sv
// Replay stream plus the 3-write/1-read regfile port bundle.
// master = controller side, slave = checker/regfile side.
interface lbr_controller_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_BITS  = 5
);
  logic                  dump_valid;
  logic                  dump_ready;
  logic                  dump_last;
  logic [DATA_WIDTH-1:0] dump_data;

  logic                  wEn0, wEn1, wEn2;
  logic [ADDR_BITS-1:0]  write_sel0, write_sel1, write_sel2;
  logic [DATA_WIDTH-1:0] write_data0, write_data1, write_data2;
  logic [ADDR_BITS-1:0]  read_sel;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output dump_valid, dump_last, dump_data,
    output wEn0, wEn1, wEn2, write_sel0, write_sel1, write_sel2,
    output write_data0, write_data1, write_data2, read_sel,
    input  dump_ready, read_data
  );

  modport slave (
    input  dump_valid, dump_last, dump_data,
    input  wEn0, wEn1, wEn2, write_sel0, write_sel1, write_sel2,
    input  write_data0, write_data1, write_data2, read_sel,
    output dump_ready, read_data
  );
endinterface

// File: rtl/lbr_dump_seq.sv
// Replay sequencer: walks records oldest->newest, one word per handshake,
// and drives the regfile read select. Counters idle at zero outside a replay.
module lbr_dump_seq
  import lbr_pkg::*;
#(
  parameter int unsigned NUM_RECORDS = 8,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned HW          = 3,
  parameter int unsigned CW          = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 active,
  input  logic [HW-1:0]        head,
  input  logic [CW-1:0]        rec_count,
  input  logic                 dump_ready,
  output logic                 dump_valid,
  output logic                 dump_last,
  output logic                 done,
  output logic [ADDR_BITS-1:0] read_sel
);

  logic [CW-1:0] rec_idx;
  logic [1:0]    word;
  int unsigned   oldest, slot;
  logic          fire;

  // Oldest slot sits rec_count behind head; current slot is rec_idx past it
  always_comb begin
    oldest = 32'(head) + NUM_RECORDS - 32'(rec_count);
    if (oldest >= NUM_RECORDS) oldest = oldest - NUM_RECORDS;
    slot = oldest + 32'(rec_idx);
    if (slot >= NUM_RECORDS) slot = slot - NUM_RECORDS;
  end

  assign dump_valid = active;
  assign dump_last  = active && (word == INFO) && (32'(rec_idx) + 1 == 32'(rec_count));
  assign fire       = active && dump_ready;
  assign done       = fire && dump_last;
  assign read_sel   = active ? ADDR_BITS'(rec_entry(slot, word)) : '0;

  // Word/record counters advance only on an accepted word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rec_idx <= '0;
      word    <= FROM;
    end else if (!active || done) begin
      rec_idx <= '0;
      word    <= FROM;
    end else if (fire) begin
      if (word == INFO) begin
        word    <= FROM;
        rec_idx <= rec_idx + 1'b1;
      end else begin
        word    <= word + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lbr_controller.sv
// Circular last-branch-record buffer over a 3-write/1-read regfile.
// Records one branch (from/to/info) per cycle, replays oldest->newest on request.
// Optional feature: define LBR_FILTER_EN to record only branch types enabled by filter_mask.
module lbr_controller
  import lbr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned NUM_RECORDS = 8,
  parameter int unsigned DROP_W      = 8,
  localparam int unsigned CW = $clog2(NUM_RECORDS + 1),
  localparam int unsigned HW = (NUM_RECORDS > 1) ? $clog2(NUM_RECORDS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  br_valid,
  input  logic [DATA_WIDTH-1:0] br_from,
  input  logic [DATA_WIDTH-1:0] br_to,
  input  logic [DATA_WIDTH-1:0] br_info,
  input  logic [3:0]            filter_mask,
  input  logic                  clear,
  input  logic                  dump_req,
  output logic                  busy,
  output logic [CW-1:0]         rec_count,
  output logic [DROP_W-1:0]     drop_count,
  lbr_controller_if.master      bus
);

  lbr_state_e    state;
  logic [HW-1:0] head, wr_slot, head_nxt;
  logic [CW-1:0] cnt_base, cnt_nxt;
  logic          type_pass, accept, in_dump, seq_done;

`ifdef LBR_FILTER_EN
  assign type_pass = |(br_info[3:0] & filter_mask);
`else
  logic unused_mask;
  assign type_pass   = 1'b1;
  assign unused_mask = ^filter_mask;
`endif

  assign in_dump = (state == DUMP);
  assign busy    = in_dump;

  // Next head/count; a clear redirects a same-cycle branch into slot 0
  always_comb begin
    accept   = reset && (state == RECORD) && br_valid && type_pass;
    wr_slot  = clear ? '0 : head;
    cnt_base = clear ? '0 : rec_count;
    head_nxt = wr_slot;
    cnt_nxt  = cnt_base;
    if (accept) begin
      head_nxt = (32'(wr_slot) == NUM_RECORDS - 1) ? '0 : wr_slot + 1'b1;
      if (32'(cnt_base) < NUM_RECORDS) cnt_nxt = cnt_base + 1'b1;
    end
  end

  // Same-cycle regfile write of all three record words
  always_comb begin
    bus.wEn0        = accept;
    bus.wEn1        = accept;
    bus.wEn2        = accept;
    bus.write_sel0  = '0;
    bus.write_sel1  = '0;
    bus.write_sel2  = '0;
    bus.write_data0 = '0;
    bus.write_data1 = '0;
    bus.write_data2 = '0;
    if (accept) begin
      bus.write_sel0  = ADDR_BITS'(rec_entry(32'(wr_slot), FROM));
      bus.write_sel1  = ADDR_BITS'(rec_entry(32'(wr_slot), TO));
      bus.write_sel2  = ADDR_BITS'(rec_entry(32'(wr_slot), INFO));
      bus.write_data0 = br_from;
      bus.write_data1 = br_to;
      bus.write_data2 = br_info;
    end
  end

  // Record/replay FSM; replay leaves head and rec_count untouched
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RECORD;
      head       <= '0;
      rec_count  <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        RECORD: begin
          head      <= head_nxt;
          rec_count <= cnt_nxt;
          if (dump_req && rec_count != '0 && cnt_nxt != '0) state <= DUMP;
        end
        DUMP: begin
          if (br_valid && type_pass && drop_count != '1) drop_count <= drop_count + 1'b1;
          if (seq_done) state <= RECORD;
        end
        default: state <= RECORD;
      endcase
    end
  end

  lbr_dump_seq #(
    .NUM_RECORDS(NUM_RECORDS),
    .ADDR_BITS  (ADDR_BITS),
    .HW         (HW),
    .CW         (CW)
  ) u_seq (
    .clock     (clock),
    .reset     (reset),
    .active    (in_dump),
    .head      (head),
    .rec_count (rec_count),
    .dump_ready(bus.dump_ready),
    .dump_valid(bus.dump_valid),
    .dump_last (bus.dump_last),
    .done      (seq_done),
    .read_sel  (bus.read_sel)
  );

  // Word is only presented while a replay is in flight
  assign bus.dump_data = bus.dump_valid ? bus.read_data : '0;

endmodule

// File: tb/tb_lbr_controller.sv
// Scoreboard bench for lbr_controller with a behavioural regfile.
module tb_lbr_controller;
  import lbr_pkg::*;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        br_valid = 1'b0;
  logic [15:0] br_from = '0, br_to = '0, br_info = '0;
  logic [3:0]  filter_mask = 4'hf;
  logic        clear = 1'b0;
  logic        dump_req = 1'b0;
  logic        busy;
  logic [3:0]  rec_count;
  logic [7:0]  drop_count;

  lbr_controller_if #(.DATA_WIDTH(16), .ADDR_BITS(5)) bus ();

  lbr_controller #(.DATA_WIDTH(16), .ADDR_BITS(5), .NUM_RECORDS(8), .DROP_W(8)) dut (
    .clock(clock), .reset(reset), .br_valid(br_valid), .br_from(br_from), .br_to(br_to),
    .br_info(br_info), .filter_mask(filter_mask), .clear(clear), .dump_req(dump_req),
    .busy(busy), .rec_count(rec_count), .drop_count(drop_count), .bus(bus)
  );

  always #5 clock = ~clock;

  // Regfile model: synchronous writes, combinational read
  logic [15:0] rf [0:31];
  always @(posedge clock) begin
    if (bus.wEn0) rf[bus.write_sel0] <= bus.write_data0;
    if (bus.wEn1) rf[bus.write_sel1] <= bus.write_data1;
    if (bus.wEn2) rf[bus.write_sel2] <= bus.write_data2;
  end
  assign bus.read_data = rf[bus.read_sel];

  int   total = 0, passed = 0;
  exp_t q[$];
  bit   mon_en = 1'b1;
  int   rmode = 0;  // 0: ready high, 1: toggle, 2: ready low
  int   wen_in_dump = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Ready pattern driver
  initial begin
    bus.dump_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (rmode)
        0:       bus.dump_ready = 1'b1;
        1:       bus.dump_ready = ~bus.dump_ready;
        default: bus.dump_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected words on handshake, checks hold-while-stalled
  logic        held = 1'b0;
  logic [15:0] held_d;
  always @(negedge clock) begin
    if (!reset) held = 1'b0;
    else begin
      if (busy && (bus.wEn0 || bus.wEn1 || bus.wEn2)) wen_in_dump++;
      if (mon_en && bus.dump_valid) begin
        if (held) chk("stall_stable", 32'(bus.dump_data), 32'(held_d));
        if (bus.dump_ready) begin
          held = 1'b0;
          if (q.size() == 0) chk("unexpected_word", 32'(bus.dump_valid), 32'(0));
          else begin
            exp_t e;
            e = q.pop_front();
            chk("dump_data", 32'(bus.dump_data), 32'(e.d));
            chk("dump_last", 32'(bus.dump_last), 32'(e.last));
          end
        end else begin
          held   = 1'b1;
          held_d = bus.dump_data;
        end
      end else held = 1'b0;
    end
  end

  task automatic branch(input logic [15:0] f, input logic [15:0] inf, input logic clr);
    br_valid = 1'b1; br_from = f; br_to = f + 16'd1; br_info = inf; clear = clr;
    @(posedge clock); #1;
    br_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic push_records(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      q.push_back('{d: 16'(i),     last: 1'b0});
      q.push_back('{d: 16'(i + 1), last: 1'b0});
      q.push_back('{d: 16'(i + 2), last: (i == last)});
    end
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    @(posedge clock); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    chk("dump_complete", 32'(ok), 32'(1));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_rec_count", 32'(rec_count), 32'(0));
    chk("rst_drop_count", 32'(drop_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_dump_valid", 32'(bus.dump_valid), 32'(0));
    chk("rst_wen", 32'({bus.wEn0, bus.wEn1, bus.wEn2}), 32'(0));
    chk("rst_read_sel", 32'(bus.read_sel), 32'(0));
    @(posedge clock); #1;
    reset = 1'b1;

    // Three branches land in slots 0..2
    branch(16'd10, 16'd12, 1'b0);
    branch(16'd20, 16'd22, 1'b0);
    branch(16'd30, 16'd32, 1'b0);
    chk("rec3_count", 32'(rec_count), 32'(3));
    chk("rf0", 32'(rf[0]), 32'(10)); chk("rf1", 32'(rf[1]), 32'(11)); chk("rf2", 32'(rf[2]), 32'(12));
    chk("rf3", 32'(rf[3]), 32'(20)); chk("rf5", 32'(rf[5]), 32'(22));
    chk("rf6", 32'(rf[6]), 32'(30)); chk("rf8", 32'(rf[8]), 32'(32));

    // Ten branches wrap the buffer; dump with ready high
    do_reset();
    for (int i = 1; i <= 10; i++) branch(16'(i), 16'(i + 2), 1'b0);
    chk("rec10_count", 32'(rec_count), 32'(8));
    rmode = 0;
    push_records(3, 10);
    start_dump();
    wait_idle(100);
    chk("post_dump_count", 32'(rec_count), 32'(8));

    // Same replay with ready toggling
    rmode = 1;
    push_records(3, 10);
    start_dump();
    wait_idle(200);

    // Drops during a stalled replay
    rmode = 2;
    @(posedge clock); #1;
    push_records(3, 10);
    start_dump();
    br_valid = 1'b1; br_from = 16'h77; br_to = 16'h78; br_info = 16'h79;
    repeat (5) begin @(posedge clock); #1; end
    br_valid = 1'b0;
    chk("drop5", 32'(drop_count), 32'(5));
    chk("drop_rec_count", 32'(rec_count), 32'(8));
    br_valid = 1'b1;
    repeat (295) begin @(posedge clock); #1; end
    br_valid = 1'b0;
    chk("drop_sat", 32'(drop_count), 32'(255));
    chk("drop_busy", 32'(busy), 32'(1));
    rmode = 0;
    wait_idle(100);
    chk("wen_during_dump", 32'(wen_in_dump), 32'(0));
    chk("rf6_after_drops", 32'(rf[6]), 32'(3));

    // Clear with a simultaneous branch goes to slot 0
    @(posedge clock); #1;
    branch(16'h55, 16'h57, 1'b1);
    chk("clr_rec_count", 32'(rec_count), 32'(1));
    chk("clr_rf0", 32'(rf[0]), 32'(16'h55));
    chk("clr_rf1", 32'(rf[1]), 32'(16'h56));
    chk("clr_rf2", 32'(rf[2]), 32'(16'h57));
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clr_empty", 32'(rec_count), 32'(0));
    start_dump();
    repeat (3) @(negedge clock);
    chk("empty_dump_valid", 32'(bus.dump_valid), 32'(0));
    chk("empty_dump_busy", 32'(busy), 32'(0));
    chk("drop_kept", 32'(drop_count), 32'(255));

    // Reset during a replay abandons it
    @(posedge clock); #1;
    branch(16'd40, 16'd42, 1'b0);
    branch(16'd50, 16'd52, 1'b0);
    mon_en = 1'b0;
    rmode = 2;
    @(posedge clock); #1;
    start_dump();
    @(posedge clock); #1;
    chk("mid_busy", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.dump_valid), 32'(0));
    chk("mid_rst_count", 32'(rec_count), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_drops", 32'(drop_count), 32'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    rmode = 0;

    // Type filter: call then ret with only ret enabled
    filter_mask = 4'b0010;
    branch(16'h100, 16'h0001, 1'b0);
    branch(16'h200, 16'h0002, 1'b0);
`ifdef LBR_FILTER_EN
    chk("filt_count", 32'(rec_count), 32'(1));
    chk("filt_rf0", 32'(rf[0]), 32'(16'h200));
    chk("filt_rf2", 32'(rf[2]), 32'(16'h0002));
`else
    chk("nofilt_count", 32'(rec_count), 32'(2));
    chk("nofilt_rf0", 32'(rf[0]), 32'(16'h100));
    chk("nofilt_rf3", 32'(rf[3]), 32'(16'h200));
`endif
    filter_mask = 4'hf;

    @(posedge clock); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
